ram_bank: RTL and testbench
===========================

// Module: ram_bank
// PURPOSE
//   Parametrised data memory for the Mini-CPU, replacing the fixed 16x16 bank.
//   - Two read ports, one write port, explicit req/ack handshakes (no CPU-state decoding inside).
//   - Multi-cycle clear sequencer, run automatically after reset and on request.
//   - The CPU control FSM drives rd_req / wr_req / clr_req from its READ / STORE / CLEAR handling.
// PARAMETERS
//   DATA_W  16           word width in bits
//   ADDR_W  4            address width
//   DEPTH   1<<ADDR_W    number of words; must be <= 2**ADDR_W
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   rd_req     in   1       read request; samples rd_addr_a/b
//   rd_addr_a  in   ADDR_W  read address, port A
//   rd_addr_b  in   ADDR_W  read address, port B
//   rd_data_a  out  DATA_W  read data, port A; held until next accepted read
//   rd_data_b  out  DATA_W  read data, port B; held until next accepted read
//   rd_valid   out  1       1-cycle pulse: rd_data_a/b updated
//   wr_req     in   1       write request; samples wr_addr/wr_data
//   wr_addr    in   ADDR_W  write address
//   wr_data    in   DATA_W  write data
//   wr_done    out  1       1-cycle pulse: write committed
//   clr_req    in   1       request a full clear
//   clr_done   out  1       1-cycle pulse: clear finished (also after the reset clear)
//   ready      out  1       1 = IDLE; requests are accepted only when ready=1
// BEHAVIOUR
//   Reset
//     - rst=1: all outputs 0, rd_data_* = 0, clear counter = 0, FSM -> CLEAR.
//   FSM
//     - CLEAR: one word per cycle, mem[cnt] <= 0, cnt++.
//     - Transition: after cnt==DEPTH-1 -> IDLE, clr_done=1 for 1 cycle. Takes DEPTH cycles.
//     - IDLE, clr_req=1 -> CLEAR. clr_req has priority: a same-cycle rd_req/wr_req is dropped,
//       with no rd_valid and no wr_done.
//     - IDLE, rd_req=1: rd_data_a/b <= mem[addr]; rd_valid pulses the next cycle (latency 1).
//     - IDLE, wr_req=1: mem[wr_addr] <= wr_data; wr_done pulses the next cycle.
//   Request handling
//     - Requests are sampled in the same cycle as ready=1. The requester holds req until ack,
//       or deasserts it; held req = one new transaction per cycle.
//     - Requests arriving while ready=0 are ignored; no ack is produced.
//   Boundary cases
//     - rd_req+wr_req, same cycle, disjoint addrs: both accepted.
//     - Same addr, read-before-write: the read returns the old word unless RAM_BYPASS_EN.
//     - rd_addr_a==rd_addr_b: both ports return the same word.
//     - Addresses >= DEPTH: write is dropped (wr_done still pulses); read returns 0.
//     - rst mid-CLEAR or mid-transaction: pending acks are lost; the clear restarts from word 0.
//   Widths and timing
//     - Memory is not reset except via the CLEAR sequence. Exact DATA_W is stored, no arithmetic.
//     - ready is a registered function of state; it is 0 in the first cycle after rst falls.
// CONFIGURATION
//   RAM_BYPASS_EN defined
//     - Same-cycle read and write to the same address forwards wr_data to the matching read
//       port(s): write-first behaviour.
//   RAM_BYPASS_EN undefined
//     - Pure read-before-write; no forwarding mux.
// STRUCTURE
//   ram_pkg
//     - State enum {RB_IDLE, RB_CLEAR}, default DATA_W/ADDR_W constants.
//   ram_clr_seq
//     - Sub-module holding the address counter, per-cycle write-zero enable and done pulse.
//     - Parent holds the array, read registers and arbitration.
// TESTING
//   1 Reset: rst 1 cycle -> ready=0 for 16 cycles, clr_done at cycle 16, all reads return 0.
//   2 Write/read: wr 0x3 <- 0xBEEF, then rd A=0x3, B=0x0 -> 1 cycle later rd_valid=1,
//     A=0xBEEF, B=0x0000.
//   3 Collision: rd A=0x5 + wr 0x5 <- 0x1234, old 0x00AA -> A=0x00AA (bypass off) /
//     0x1234 (RAM_BYPASS_EN).
//   4 Clear priority: clr_req+wr_req, same cycle -> no wr_done, 16 cycles busy, clr_done,
//     all words 0.
//   5 Reset mid-clear at cnt=7 -> clear restarts at 0, clr_done 16 cycles after rst falls.
//   6 Requests while ready=0 (during clear): wr 0x2 <- 0xFFFF -> no wr_done;
//     word 0x2 still 0 after clear.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and default sizes for the ram_bank data memory.
package ram_pkg;

    // Controller states: serving requests, or sweeping zeros through the array.
    typedef enum logic {
        RB_IDLE,
        RB_CLEAR
    } rb_state_e;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 4;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer for ram_bank: walks the word address from 0 to DEPTH-1, one word per
// cycle while run=1, and pulses done the cycle after the last word is zeroed.
module ram_clr_seq #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] cnt_q;

    // Counter wraps to 0 after the last word, so a later clear always starts at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= run && last;
            if (run) begin
                cnt_q <= last ? '0 : cnt_q + 1'b1;
            end
        end
    end

    // Write-zero strobe and address follow the counter directly.
    always_comb begin
        we   = run;
        addr = cnt_q;
        last = (cnt_q == LAST_ADDR);
    end

endmodule

// File: rtl/ram_bank.sv
// ram_bank: parametrised data memory with two read ports, one write port, req/ack
// handshakes and a multi-cycle clear run after reset and on request.
// Optional feature macro: RAM_BYPASS_EN (write-first forwarding on same-address collisions).
module ram_bank
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    input  logic              clr_req,
    output logic              clr_done,
    output logic              ready
);

    rb_state_e         state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_a_d, rd_b_d;
    logic              rd_acc, wr_acc;
    logic              clr_run, clr_we, clr_last;
    logic [ADDR_W-1:0] clr_addr;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    ram_clr_seq #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_clr_seq (
        .clk (clk),
        .rst (rst),
        .run (clr_run),
        .we  (clr_we),
        .addr(clr_addr),
        .last(clr_last),
        .done(clr_done)
    );

    // Next-state logic, ready decode and request arbitration (clear wins over rd/wr).
    always_comb begin
        state_d = state_q;
        ready   = (state_q == RB_IDLE);
        clr_run = (state_q == RB_CLEAR);
        rd_acc  = ready && !rst && rd_req && !clr_req;
        wr_acc  = ready && !rst && wr_req && !clr_req;
        unique case (state_q)
            RB_IDLE:  if (clr_req) state_d = RB_CLEAR;
            RB_CLEAR: if (clr_last) state_d = RB_IDLE;
            default:  state_d = RB_CLEAR;
        endcase
    end

    // State register; reset always lands in CLEAR so the array is swept before use.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RB_CLEAR;
        else     state_q <= state_d;
    end

    // Array update: the clear sweep and accepted writes never overlap (writes need IDLE).
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc && in_range(wr_addr)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data selection; out-of-range addresses read as zero.
    always_comb begin
        rd_a_d = in_range(rd_addr_a) ? mem[rd_addr_a] : '0;
        rd_b_d = in_range(rd_addr_b) ? mem[rd_addr_b] : '0;
`ifdef RAM_BYPASS_EN
        if (wr_acc && in_range(wr_addr) && (wr_addr == rd_addr_a)) rd_a_d = wr_data;
        if (wr_acc && in_range(wr_addr) && (wr_addr == rd_addr_b)) rd_b_d = wr_data;
`endif
    end

    // Read registers hold their value until the next accepted read; acks are 1-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            wr_done  <= wr_acc;
            if (rd_acc) begin
                rd_data_a <= rd_a_d;
                rd_data_b <= rd_b_d;
            end
        end
    end

endmodule

// File: tb/tb_ram_bank.sv
// Directed testbench for ram_bank: reset clear, read/write, collisions, clear priority,
// reset mid-clear and requests ignored while busy.
module tb_ram_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_done;
    logic        clr_req;
    logic        clr_done;
    logic        ready;

    int checks = 0;
    int failures = 0;

    ram_bank dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .rd_valid (rd_valid),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .clr_req  (clr_req),
        .clr_done (clr_done),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step until clr_done, bounded; checks cycle count and that ready stayed low before it.
    task automatic wait_clear(input string tag, input int exp_cycles);
        int n = 0;
        logic early = 1'b0;
        do begin
            tick();
            n++;
            if (ready && !clr_done) early = 1'b1;
        end while (!clr_done && n < 40);
        check({tag, "_cycles"}, n, exp_cycles);
        check({tag, "_busy"}, {31'd0, early}, 0);
        check({tag, "_ready"}, {31'd0, ready}, 1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_req = 1'b0;
        check("wr_done", {31'd0, wr_done}, 1);
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [15:0] ea, input logic [15:0] eb);
        rd_req = 1'b1; rd_addr_a = a; rd_addr_b = b;
        tick();
        rd_req = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 1);
        check({tag, "_a"}, {16'd0, rd_data_a}, {16'd0, ea});
        check({tag, "_b"}, {16'd0, rd_data_b}, {16'd0, eb});
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; clr_req = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_data = '0;
        tick();
        tick();
        check("rst_ready", {31'd0, ready}, 0);
        check("rst_rd_valid", {31'd0, rd_valid}, 0);
        check("rst_wr_done", {31'd0, wr_done}, 0);
        check("rst_clr_done", {31'd0, clr_done}, 0);
        check("rst_rd_data", {rd_data_a, rd_data_b}, 0);

        // 1: reset clear takes 16 cycles, then every word reads 0.
        rst = 1'b0;
        wait_clear("rst_clear", 16);
        tick();
        check("clr_done_pulse", {31'd0, clr_done}, 0);
        for (int i = 0; i < 8; i++) begin
            do_read("init_zero", 4'(i), 4'(15 - i), 16'h0000, 16'h0000);
        end

        // 2: write then read with a disjoint B address; data holds after the pulse.
        do_write(4'h3, 16'hBEEF);
        tick();
        check("wr_done_pulse", {31'd0, wr_done}, 0);
        do_read("wr_rd", 4'h3, 4'h0, 16'hBEEF, 16'h0000);
        tick();
        check("rd_valid_pulse", {31'd0, rd_valid}, 0);
        check("rd_hold", {16'd0, rd_data_a}, 32'h0000_BEEF);
        do_read("same_addr", 4'h3, 4'h3, 16'hBEEF, 16'hBEEF);

        // 3: same-cycle read/write collision on word 5; port B reads a disjoint word.
        do_write(4'h5, 16'h00AA);
        rd_req = 1'b1; rd_addr_a = 4'h5; rd_addr_b = 4'h3;
        wr_req = 1'b1; wr_addr = 4'h5; wr_data = 16'h1234;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        check("coll_valid", {31'd0, rd_valid}, 1);
        check("coll_wr_done", {31'd0, wr_done}, 1);
`ifdef RAM_BYPASS_EN
        check("coll_a", {16'd0, rd_data_a}, 32'h0000_1234);
`else
        check("coll_a", {16'd0, rd_data_a}, 32'h0000_00AA);
`endif
        check("coll_b", {16'd0, rd_data_b}, 32'h0000_BEEF);
        do_read("coll_after", 4'h5, 4'h5, 16'h1234, 16'h1234);

        // Held wr_req: one transaction per cycle.
        wr_req = 1'b1; wr_addr = 4'h7; wr_data = 16'h1111;
        tick();
        check("held_wr1", {31'd0, wr_done}, 1);
        wr_addr = 4'h8; wr_data = 16'h2222;
        tick();
        wr_req = 1'b0;
        check("held_wr2", {31'd0, wr_done}, 1);
        do_read("held_rd", 4'h7, 4'h8, 16'h1111, 16'h2222);

        // 4 + 6: clear beats a same-cycle write; a write during the clear is ignored.
        clr_req = 1'b1; wr_req = 1'b1; wr_addr = 4'h9; wr_data = 16'h5555;
        tick();
        clr_req = 1'b0; wr_req = 1'b0;
        check("clr_prio_wr_done", {31'd0, wr_done}, 0);
        check("clr_prio_ready", {31'd0, ready}, 0);
        for (int i = 0; i < 10; i++) tick();
        wr_req = 1'b1; wr_addr = 4'h2; wr_data = 16'hFFFF;
        tick();
        wr_req = 1'b0;
        check("busy_wr_done", {31'd0, wr_done}, 0);
        wait_clear("clr_req", 5);
        do_read("clr_zero_a", 4'h2, 4'h3, 16'h0000, 16'h0000);
        do_read("clr_zero_b", 4'h5, 4'h9, 16'h0000, 16'h0000);
        do_read("clr_zero_c", 4'h7, 4'h8, 16'h0000, 16'h0000);

        // 5: reset at cnt=7 restarts the clear from word 0.
        do_write(4'hC, 16'hA5A5);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_ready", {31'd0, ready}, 0);
        check("mid_rst_clr_done", {31'd0, clr_done}, 0);
        rst = 1'b0;
        wait_clear("mid_rst", 16);
        do_read("mid_rst_zero", 4'hC, 4'h0, 16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
